matrix_3x3_gen: RTL and testbench

Line-buffer controller and 3×3 window generator for the Gaussian filter path. It consumes the raster pixel stream and drives two external line-buffer FIFO instances (`matrix_fifo_buf`, cascaded A→B). It presents every input pixel together with its two predecessors in the current row and in the two previous rows, as nine registered window taps for the downstream 3×3 kernel stage. The block holds no pixel storage beyond the window and pipeline registers; the line storage lives in the FIFOs.

---
 rtl/matrix_3x3_gen_pkg.sv | 14 +
 rtl/matrix_3x3_gen_row_shift.sv | 32 +++
 rtl/matrix_3x3_gen.sv | 148 ++++++++++++++
 tb/tb_matrix_3x3_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_3x3_gen_pkg.sv
// Shared definitions for the 3x3 window path: pipeline latency, default pixel
// width and the nine-tap window record consumed by the Gaussian kernel stage.
package matrix_pkg;

    localparam int MATRIX_LAT = 2;
    localparam int DATA_W_DEF = 8;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] p11, p12, p13;
        logic [DATA_W_DEF-1:0] p21, p22, p23;
        logic [DATA_W_DEF-1:0] p31, p32, p33;
    } window_t;

endpackage

// File: rtl/matrix_3x3_gen_row_shift.sv
// One window row: three-deep shift register, tap3 newest, with synchronous
// clear (line start) taking priority over the shift enable.
module matrix_row_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tap1,
    output logic [DATA_W-1:0] tap2,
    output logic [DATA_W-1:0] tap3
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap1 <= '0;
            tap2 <= '0;
            tap3 <= '0;
        end else if (clr) begin
            tap1 <= '0;
            tap2 <= '0;
            tap3 <= '0;
        end else if (en) begin
            tap1 <= tap2;
            tap2 <= tap3;
            tap3 <= din;
        end
    end

endmodule

// File: rtl/matrix_3x3_gen.sv
// Line-buffer controller and 3x3 window generator: drives two cascaded external
// line FIFOs (A = line n-1, B = line n-2) and shifts the three rows into taps.
module matrix_3x3_gen
    import matrix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_vsync,
    input  logic              pre_href,
    input  logic              pre_de,
    input  logic [DATA_W-1:0] pre_data,
    output logic              fifo_rst,
    output logic              fa_wr_en,
    output logic [DATA_W-1:0] fa_wr_data,
    output logic              fa_rd_en,
    input  logic [DATA_W-1:0] fa_rd_data,
    input  logic              fa_full,
    input  logic              fa_empty,
    output logic              fb_wr_en,
    output logic [DATA_W-1:0] fb_wr_data,
    output logic              fb_rd_en,
    input  logic [DATA_W-1:0] fb_rd_data,
    input  logic              fb_full,
    input  logic              fb_empty,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33,
    output logic              matrix_de,
    output logic              matrix_href,
    output logic              matrix_vsync,
    output logic              buf_err
);

    logic       vsync_d, href_d;
    logic       vs_rise, href_rise, href_fall;
    logic [1:0] lcnt;
    logic       lcnt_ge1, lcnt_ge2;
    logic       rd_b_d;
    logic       err_hit;
    logic [DATA_W-1:0] row3_q;

    // {vsync, href, de} per stage; stage 1 de is the window shift enable
    logic [MATRIX_LAT:1][2:0] sync_pipe;

    logic [2:0][DATA_W-1:0] row_in, tap1, tap2, tap3;

    assign vs_rise   = pre_vsync & ~vsync_d;
    assign href_rise = pre_href  & ~href_d;
    assign href_fall = ~pre_href &  href_d;
    assign lcnt_ge1  = (lcnt >= 2'd1);
    assign lcnt_ge2  = (lcnt >= 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
            lcnt    <= 2'd0;
        end else begin
            vsync_d <= pre_vsync;
            href_d  <= pre_href;
            if (vs_rise)
                lcnt <= 2'd0;
            else if (href_fall && lcnt != 2'd2)
                lcnt <= lcnt + 2'd1;
        end
    end

    assign fa_wr_en   = pre_de;
    assign fa_wr_data = pre_data;
    assign fa_rd_en   = pre_de & lcnt_ge1;
    assign fb_rd_en   = pre_de & lcnt_ge2;
    assign fb_wr_data = fa_rd_data;

    assign err_hit = (fa_wr_en & fa_full)  | (fb_wr_en & fb_full) |
                     (fa_rd_en & fa_empty) | (fb_rd_en & fb_empty);

    // fifo_rst comes out of reset high so the FIFOs are flushed until the first edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rst <= 1'b1;
            buf_err  <= 1'b0;
        end else begin
            fifo_rst <= vs_rise;
            if (vs_rise)
                buf_err <= 1'b0;
            else if (err_hit)
                buf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_wr_en  <= 1'b0;
            rd_b_d    <= 1'b0;
            row3_q    <= '0;
            sync_pipe <= '0;
        end else begin
            fb_wr_en     <= fa_rd_en;
            rd_b_d       <= fb_rd_en;
            if (pre_de)
                row3_q <= pre_data;
            sync_pipe[1] <= {pre_vsync, pre_href, pre_de};
            for (int i = 2; i <= MATRIX_LAT; i++)
                sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    // FIFO read data lands one cycle after rd_en; the delayed enables gate it
    assign row_in[0] = rd_b_d   ? fb_rd_data : '0;
    assign row_in[1] = fb_wr_en ? fa_rd_data : '0;
    assign row_in[2] = row3_q;

    for (genvar r = 0; r < 3; r++) begin : g_row
        matrix_row_shift #(.DATA_W(DATA_W)) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (href_rise),
            .en    (sync_pipe[1][0]),
            .din   (row_in[r]),
            .tap1  (tap1[r]),
            .tap2  (tap2[r]),
            .tap3  (tap3[r])
        );
    end

    assign matrix_p11 = tap1[0];
    assign matrix_p12 = tap2[0];
    assign matrix_p13 = tap3[0];
    assign matrix_p21 = tap1[1];
    assign matrix_p22 = tap2[1];
    assign matrix_p23 = tap3[1];
    assign matrix_p31 = tap1[2];
    assign matrix_p32 = tap2[2];
    assign matrix_p33 = tap3[2];

    assign matrix_vsync = sync_pipe[MATRIX_LAT][2];
    assign matrix_href  = sync_pipe[MATRIX_LAT][1];
    assign matrix_de    = sync_pipe[MATRIX_LAT][0];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen: behavioural line FIFOs (depth 8, read data one
// cycle after rd_en) plus a table of 3x4 frame windows computed by hand.
module tb_matrix_3x3_gen;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_vsync, pre_href, pre_de;
    logic [7:0] pre_data;
    logic       fifo_rst;
    logic       fa_wr_en, fa_rd_en, fb_wr_en, fb_rd_en;
    logic [7:0] fa_wr_data, fb_wr_data, fa_rd_data, fb_rd_data;
    logic       fa_full, fa_empty, fb_full, fb_empty;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic       matrix_de, matrix_href, matrix_vsync, buf_err;

    always #5 clk = ~clk;

    matrix_3x3_gen #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_vsync(pre_vsync), .pre_href(pre_href), .pre_de(pre_de), .pre_data(pre_data),
        .fifo_rst(fifo_rst),
        .fa_wr_en(fa_wr_en), .fa_wr_data(fa_wr_data), .fa_rd_en(fa_rd_en), .fa_rd_data(fa_rd_data),
        .fa_full(fa_full), .fa_empty(fa_empty),
        .fb_wr_en(fb_wr_en), .fb_wr_data(fb_wr_data), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
        .fb_full(fb_full), .fb_empty(fb_empty),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .matrix_de(matrix_de), .matrix_href(matrix_href), .matrix_vsync(matrix_vsync),
        .buf_err(buf_err)
    );

    // Behavioural FIFO pair, index 0 = A, 1 = B
    logic [7:0] fm [2][DEPTH];
    int         fcnt [2];
    int         fwp [2];
    int         frp [2];
    logic [7:0] frd [2];
    logic       fwe [2];
    logic       fre [2];
    logic [7:0] fwd [2];

    assign fwe[0] = fa_wr_en;  assign fwe[1] = fb_wr_en;
    assign fre[0] = fa_rd_en;  assign fre[1] = fb_rd_en;
    assign fwd[0] = fa_wr_data; assign fwd[1] = fb_wr_data;
    assign fa_rd_data = frd[0]; assign fb_rd_data = frd[1];
    assign fa_full  = (fcnt[0] == DEPTH); assign fa_empty = (fcnt[0] == 0);
    assign fb_full  = (fcnt[1] == DEPTH); assign fb_empty = (fcnt[1] == 0);

    initial begin
        for (int k = 0; k < 2; k++) begin
            fcnt[k] = 0; fwp[k] = 0; frp[k] = 0; frd[k] = 8'h00;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (fifo_rst) begin
                fcnt[k] <= 0; fwp[k] <= 0; frp[k] <= 0;
            end else begin
                if (fwe[k] && fcnt[k] < DEPTH) begin
                    fm[k][fwp[k]] <= fwd[k];
                    fwp[k] <= (fwp[k] + 1) % DEPTH;
                end
                if (fre[k] && fcnt[k] > 0) begin
                    frd[k] <= fm[k][frp[k]];
                    frp[k] <= (frp[k] + 1) % DEPTH;
                end
                fcnt[k] <= fcnt[k] + ((fwe[k] && fcnt[k] < DEPTH) ? 1 : 0)
                                   - ((fre[k] && fcnt[k] > 0) ? 1 : 0);
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [71:0] win_now;
    assign win_now = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

    // Window capture on every output pixel, and optional de latency check
    logic [71:0] obs[$];
    logic [1:0]  de_hist = 2'b00;
    bit          chk_lat = 1'b0;

    always @(negedge clk) begin
        if (matrix_de === 1'b1) obs.push_back(win_now);
        if (chk_lat) chk("de_lat", {71'd0, matrix_de}, {71'd0, de_hist[1]});
        de_hist <= {de_hist[0], pre_de};
    end

    typedef struct {
        logic [7:0]  data;
        bit          last;
        logic [71:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input string tag);
        int hi;
        hi = 0;
        pre_vsync = 1'b0;
        tick();
        pre_vsync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fifo_rst) hi++;
        end
        chk({tag, "_fifo_rst_cycles"}, 72'(hi), 72'd1);
    endtask

    // Drives the first n table pixels of a frame; gap inserts one idle de cycle
    task automatic drive_pixels(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            pre_href = 1'b1;
            pre_de   = 1'b1;
            pre_data = tbl[i].data;
            tick();
            pre_de = 1'b0;
            if (gap) tick();
            if (tbl[i].last) begin
                pre_href = 1'b0;
                tick();
                tick();
            end
        end
    endtask

    task automatic run_frame(input string tag, input bit gap);
        frame_start(tag);
        obs.delete();
        chk_lat = gap;
        drive_pixels(12, gap);
        repeat (4) tick();
        chk_lat = 1'b0;
        chk({tag, "_count"}, 72'(obs.size()), 72'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_win%0d", tag, i), (i < obs.size()) ? obs[i] : 72'hx, tbl[i].exp);
        chk({tag, "_buf_err"}, {71'd0, buf_err}, 72'd0);
    endtask

    initial begin
        // pixel = 16*line + col; exp = {p11,p12,p13, p21,p22,p23, p31,p32,p33}
        tbl[0]  = '{8'h00, 1'b0, 72'h00_00_00_00_00_00_00_00_00};
        tbl[1]  = '{8'h01, 1'b0, 72'h00_00_00_00_00_00_00_00_01};
        tbl[2]  = '{8'h02, 1'b0, 72'h00_00_00_00_00_00_00_01_02};
        tbl[3]  = '{8'h03, 1'b1, 72'h00_00_00_00_00_00_01_02_03};
        tbl[4]  = '{8'h10, 1'b0, 72'h00_00_00_00_00_00_00_00_10};
        tbl[5]  = '{8'h11, 1'b0, 72'h00_00_00_00_00_01_00_10_11};
        tbl[6]  = '{8'h12, 1'b0, 72'h00_00_00_00_01_02_10_11_12};
        tbl[7]  = '{8'h13, 1'b1, 72'h00_00_00_01_02_03_11_12_13};
        tbl[8]  = '{8'h20, 1'b0, 72'h00_00_00_00_00_10_00_00_20};
        tbl[9]  = '{8'h21, 1'b0, 72'h00_00_01_00_10_11_00_20_21};
        tbl[10] = '{8'h22, 1'b0, 72'h00_01_02_10_11_12_20_21_22};
        tbl[11] = '{8'h23, 1'b1, 72'h01_02_03_11_12_13_21_22_23};

        rst_n = 1'b0; pre_vsync = 1'b0; pre_href = 1'b0; pre_de = 1'b0; pre_data = 8'h00;
        #23;
        chk("rst_win", win_now, 72'd0);
        chk("rst_sync", {69'd0, matrix_de, matrix_href, matrix_vsync}, 72'd0);
        chk("rst_fifo_rst", {71'd0, fifo_rst}, 72'd1);
        chk("rst_buf_err", {71'd0, buf_err}, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fifo_rst_hold", {71'd0, fifo_rst}, 72'd1);
        tick();
        chk("fifo_rst_release", {71'd0, fifo_rst}, 72'd0);
        tick();

        run_frame("f1", 1'b0);
        run_frame("gap", 1'b1);
        run_frame("f2", 1'b0);

        // Over-long line on line 0: FIFO A fills at 8, the 9th write overflows
        frame_start("ovf");
        pre_href = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            pre_de = 1'b1; pre_data = 8'(i);
            tick();
            if (i == DEPTH - 1) chk("ovf_before", {71'd0, buf_err}, 72'd0);
        end
        chk("ovf_set", {71'd0, buf_err}, 72'd1);
        pre_de = 1'b0; pre_href = 1'b0;
        repeat (6) tick();
        chk("ovf_sticky", {71'd0, buf_err}, 72'd1);
        pre_vsync = 1'b0;
        tick();
        chk("ovf_sticky_vs_low", {71'd0, buf_err}, 72'd1);
        pre_vsync = 1'b1;
        tick();
        chk("ovf_clear", {71'd0, buf_err}, 72'd0);
        repeat (3) tick();

        // Reset pulse in the middle of line 2
        frame_start("mid");
        drive_pixels(10, 1'b0);
        chk("mid_win_live", {71'd0, (win_now != 72'd0)}, 72'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_win", win_now, 72'd0);
        chk("mid_rst_sync", {69'd0, matrix_de, matrix_href, matrix_vsync}, 72'd0);
        chk("mid_rst_fifo_rst", {71'd0, fifo_rst}, 72'd1);
        pre_href = 1'b0; pre_vsync = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        run_frame("post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
